present_sbox_layer_ctrl: RTL and testbench

- Sequencer that applies the PRESENT S-box layer to a 3-share masked 64-bit state.
- Time-multiplexes one first-order uniform threshold S-box instance (3 shares, registered G stage, combinational F stage) over the 16 nibbles.
- Sits between the round-state registers and the shared S-box.
- Start/done handshake; one nibble issued per cycle, pipelined against the S-box's one-cycle latency.

---
 rtl/present_sbox_layer_ctrl.sv | 111 +++++++++++
 tb/tb_present_sbox_layer_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/present_sbox_layer_ctrl.sv
// Sequencer for the PRESENT S-box layer over a 3-share masked state.
// One shared threshold S-box is fed one nibble per cycle; results shift back in one cycle later.
module present_sbox_layer_ctrl #(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   state_in1,
  input  logic [4*NIBBLES-1:0]   state_in2,
  input  logic [4*NIBBLES-1:0]   state_in3,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   state_out1,
  output logic [4*NIBBLES-1:0]   state_out2,
  output logic [4*NIBBLES-1:0]   state_out3,
  output logic [3:0]             sbox_in1,
  output logic [3:0]             sbox_in2,
  output logic [3:0]             sbox_in3,
  output logic                   sbox_en,
  input  logic [3:0]             sbox_out1,
  input  logic [3:0]             sbox_out2,
  input  logic [3:0]             sbox_out3
);

  localparam int unsigned W = 4 * NIBBLES;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StFin} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     in1_q, in2_q, in3_q;
  logic [W-1:0]     res1_q, res2_q, res3_q;
  logic             cap_q;

  assign state_out1 = res1_q;
  assign state_out2 = res2_q;
  assign state_out3 = res3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      in3_q    <= '0;
      res1_q   <= '0;
      res2_q   <= '0;
      res3_q   <= '0;
      cap_q    <= 1'b0;
      sbox_in1 <= '0;
      sbox_in2 <= '0;
      sbox_in3 <= '0;
      sbox_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done  <= 1'b0;
      // S-box output is valid the cycle after each enabled G-stage load.
      cap_q <= sbox_en;
      if (cap_q) begin
        res1_q <= {sbox_out1, res1_q[W-1:4]};
        res2_q <= {sbox_out2, res2_q[W-1:4]};
        res3_q <= {sbox_out3, res3_q[W-1:4]};
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // Nibble 0 goes straight into the S-box input flops; the rest wait in the shifters.
            sbox_in1 <= state_in1[3:0];
            sbox_in2 <= state_in2[3:0];
            sbox_in3 <= state_in3[3:0];
            in1_q    <= state_in1 >> 4;
            in2_q    <= state_in2 >> 4;
            in3_q    <= state_in3 >> 4;
            sbox_en  <= 1'b1;
            busy     <= 1'b1;
            cnt_q    <= '0;
            state_q  <= StFeed;
          end
        end
        StFeed: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            sbox_en <= 1'b0;
            state_q <= StDrain;
          end else begin
            sbox_in1 <= in1_q[3:0];
            sbox_in2 <= in2_q[3:0];
            sbox_in3 <= in3_q[3:0];
            in1_q    <= in1_q >> 4;
            in2_q    <= in2_q >> 4;
            in3_q    <= in3_q >> 4;
          end
        end
        StDrain: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StFin;
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Directed bench for present_sbox_layer_ctrl with a behavioural 3-share S-box model
// whose output shares 2/3 are simple functions of input shares 2/3.
module tb_present_sbox_layer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] state_in1, state_in2, state_in3;
  logic        busy, done, sbox_en;
  logic [63:0] state_out1, state_out2, state_out3;
  logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
  logic [3:0]  sbox_out1, sbox_out2, sbox_out3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  present_sbox_layer_ctrl #(.NIBBLES(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .state_in1(state_in1), .state_in2(state_in2), .state_in3(state_in3),
    .busy(busy), .done(done),
    .state_out1(state_out1), .state_out2(state_out2), .state_out3(state_out3),
    .sbox_in1(sbox_in1), .sbox_in2(sbox_in2), .sbox_in3(sbox_in3), .sbox_en(sbox_en),
    .sbox_out1(sbox_out1), .sbox_out2(sbox_out2), .sbox_out3(sbox_out3)
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;  // S[15]..S[0]
    return t[4*x +: 4];
  endfunction

  function automatic logic [3:0] rot4(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  function automatic logic [63:0] exp_out2(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = rot4(v[4*i +: 4]);
    return r;
  endfunction

  // Behavioural shared S-box: registered G stage, combinational F stage.
  logic [3:0] g1 = '0, g2 = '0, g3 = '0;
  always @(posedge clk) if (sbox_en) begin
    g1 <= sbox_in1;
    g2 <= sbox_in2;
    g3 <= sbox_in3;
  end
  assign sbox_out2 = rot4(g2);
  assign sbox_out3 = ~g3;
  assign sbox_out1 = sb(g1 ^ g2 ^ g3) ^ sbox_out2 ^ sbox_out3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Runs one layer; returns cycle of done (relative to start edge) and S-box enable profile.
  task automatic run_layer(input logic [63:0] i1, input logic [63:0] i2, input logic [63:0] i3,
                           output int lat, output int en_first, output int en_last,
                           output int en_cnt, output logic [3:0] first_nib);
    int n;
    lat = -1; en_first = -1; en_last = -1; en_cnt = 0; first_nib = 'x;
    @(negedge clk);
    state_in1 = i1; state_in2 = i2; state_in3 = i3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    state_in1 = '1; state_in2 = '1; state_in3 = '1;
    n = 1;
    while (1) begin
      if (n == 1) first_nib = sbox_in1 ^ sbox_in2 ^ sbox_in3;
      if (sbox_en) begin
        if (en_first < 0) en_first = n;
        en_last = n;
        en_cnt++;
      end
      if (done) begin
        lat = n;
        break;
      end
      if (n >= 40) break;
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [63:0] p;
    logic [63:0] m2;
    logic [63:0] m3;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat, ef, el, ec;
    logic [3:0] fn;
    logic [63:0] acc, p, m2, m3, r;
    int d1, d2, n, dcnt;
    logic [63:0] r1, r2;

    vecs[0] = '{64'h0123456789ABCDEF, 64'h0, 64'h0, 64'hC56B90AD3EF84712};
    vecs[1] = '{64'h0123456789ABCDEF, 64'hDEADBEEF01234567, 64'h0F1E2D3C4B5A6978,
                64'hC56B90AD3EF84712};
    vecs[2] = '{64'h0, 64'h0, 64'h0, 64'hCCCCCCCCCCCCCCCC};
    vecs[3] = '{64'h0, 64'hFFFF0000AAAA5555, 64'h123456789ABCDEF0, 64'hCCCCCCCCCCCCCCCC};
    vecs[4] = '{64'h000000000000000F, 64'h8badf00dcafebabe, 64'h0, 64'hCCCCCCCCCCCCCCC2};

    rst = 1'b1; start = 1'b0;
    state_in1 = '0; state_in2 = '0; state_in3 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc |= {busy, done, sbox_en, sbox_in1, sbox_in2, sbox_in3} | state_out1 | state_out2
             | state_out3;
    end
    chk("idle_outputs", acc, 64'h0);
    chk("idle_busy", {63'b0, busy}, 64'h0);

    foreach (vecs[k]) begin
      p  = vecs[k].p;
      m2 = vecs[k].m2;
      m3 = vecs[k].m3;
      run_layer(p ^ m2 ^ m3, m2, m3, lat, ef, el, ec, fn);
      chk($sformatf("v%0d_latency", k), 64'(lat), 64'd18);
      chk($sformatf("v%0d_en_window", k), {32'(ef), 32'(el)}, {32'd1, 32'd16});
      chk($sformatf("v%0d_en_count", k), 64'(ec), 64'd16);
      chk($sformatf("v%0d_first_nib", k), 64'(fn), 64'(p[3:0]));
      chk($sformatf("v%0d_recombined", k), state_out1 ^ state_out2 ^ state_out3, vecs[k].exp);
      chk($sformatf("v%0d_share2", k), state_out2, exp_out2(m2));
      chk($sformatf("v%0d_share3", k), state_out3, ~m3);
      chk($sformatf("v%0d_busy_fin", k), {63'b0, busy}, 64'h0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", k), {63'b0, done}, 64'h0);
      chk($sformatf("v%0d_stable", k), state_out1 ^ state_out2 ^ state_out3, vecs[k].exp);
    end

    // Random masks.
    for (int i = 0; i < 1000; i++) begin
      m2 = {$urandom, $urandom};
      m3 = {$urandom, $urandom};
      run_layer(64'h0123456789ABCDEF ^ m2 ^ m3, m2, m3, lat, ef, el, ec, fn);
      chk($sformatf("rand%0d", i), state_out1 ^ state_out2 ^ state_out3, 64'hC56B90AD3EF84712);
    end

    // Start held high: back-to-back layers every 19 cycles, inputs sampled only in IDLE.
    @(negedge clk);
    state_in1 = 64'h0123456789ABCDEF; state_in2 = '0; state_in3 = '0; start = 1'b1;
    @(negedge clk);
    n = 1; d1 = -1; d2 = -1; dcnt = 0; r1 = '0; r2 = '0;
    state_in1 = '0;
    while (n <= 50) begin
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = n; r1 = state_out1 ^ state_out2 ^ state_out3; end
        if (dcnt == 2) begin d2 = n; r2 = state_out1 ^ state_out2 ^ state_out3; end
      end
      if (n == 40) start = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("held_done1_cycle", 64'(d1), 64'd18);
    chk("held_done2_cycle", 64'(d2), 64'd37);
    chk("held_done_count", 64'(dcnt), 64'd2);
    chk("held_result1", r1, 64'hC56B90AD3EF84712);
    chk("held_result2", r2, 64'hCCCCCCCCCCCCCCCC);
    repeat (10) @(negedge clk);

    // Reset in FEED cycle 7 aborts the layer.
    state_in1 = 64'hFEDCBA9876543210; state_in2 = 64'h1111; state_in3 = 64'h2222;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_en", {63'b0, sbox_en}, 64'h1);
    rst = 1'b1;
    #1;
    chk("abort_busy_en", {62'b0, busy, sbox_en}, 64'h0);
    chk("abort_outputs", state_out1 | state_out2 | state_out3, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'h0);
    run_layer(64'h0123456789ABCDEF, 64'h0, 64'h0, lat, ef, el, ec, fn);
    chk("after_abort_latency", 64'(lat), 64'd18);
    chk("after_abort_result", state_out1 ^ state_out2 ^ state_out3, 64'hC56B90AD3EF84712);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
